// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit:
// ALU/branch/immediate encodings, FSM states, the registered control word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_XOR   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SLL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_PASSB = 4'b1000,
    ALU_OR    = 4'b1001,
    ALU_AND   = 4'b1010
  } aluop_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_EQ   = 3'b001,
    BR_NE   = 3'b010,
    BR_LT   = 3'b011,
    BR_GE   = 3'b100,
    BR_LTU  = 3'b101,
    BR_GEU  = 3'b110,
    BR_JUMP = 3'b111
  } brop_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_B = 3'b001,
    IMM_S = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_type_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } sel_wb_e;

  // Which path the instruction takes after EXECUTE.
  typedef enum logic [1:0] {
    ACC_NONE   = 2'b00,
    ACC_LOAD   = 2'b01,
    ACC_STORE  = 2'b10,
    ACC_BRANCH = 2'b11
  } access_e;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  typedef struct packed {
    logic      sel_opr_a;
    logic      sel_opr_b;
    sel_wb_e   sel_wb;
    imm_type_e imm_type;
    aluop_e    aluop;
    brop_e     brop;
    access_e   access;
  } ctrl_word_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // alt selects SUB over ADD and SRA over SRL; callers decide when it applies.
  function automatic aluop_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    aluop_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decode: {opcode, funct3, funct7} -> control word plus
// an illegal-instruction flag.
module rv32i_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output ctrl_word_t  ctrl,
  output logic        illegal
);

  always_comb begin
    ctrl.sel_opr_a = 1'b0;
    ctrl.sel_opr_b = 1'b0;
    ctrl.sel_wb    = WB_ALU;
    ctrl.imm_type  = IMM_I;
    ctrl.aluop     = ALU_ADD;
    ctrl.brop      = BR_NONE;
    ctrl.access    = ACC_NONE;
    illegal        = 1'b0;

    case (opcode)
      OPC_LUI: begin
        ctrl.sel_opr_b = 1'b1;
        ctrl.imm_type  = IMM_U;
        ctrl.aluop     = ALU_PASSB;
      end
      OPC_AUIPC: begin
        ctrl.sel_opr_a = 1'b1;
        ctrl.sel_opr_b = 1'b1;
        ctrl.imm_type  = IMM_U;
      end
      OPC_JAL: begin
        ctrl.sel_opr_a = 1'b1;
        ctrl.sel_opr_b = 1'b1;
        ctrl.imm_type  = IMM_J;
        ctrl.sel_wb    = WB_PC4;
        ctrl.brop      = BR_JUMP;
      end
      OPC_JALR: begin
        ctrl.sel_opr_b = 1'b1;
        ctrl.imm_type  = IMM_I;
        ctrl.sel_wb    = WB_PC4;
        ctrl.brop      = BR_JUMP;
      end
      OPC_BRANCH: begin
        // ALU subtracts rs1-rs2; the comparator applies brop to the operands.
        ctrl.imm_type = IMM_B;
        ctrl.aluop    = ALU_SUB;
        ctrl.access   = ACC_BRANCH;
        case (funct3)
          3'b000:  ctrl.brop = BR_EQ;
          3'b001:  ctrl.brop = BR_NE;
          3'b100:  ctrl.brop = BR_LT;
          3'b101:  ctrl.brop = BR_GE;
          3'b110:  ctrl.brop = BR_LTU;
          3'b111:  ctrl.brop = BR_GEU;
          default: ctrl.brop = BR_NONE;
        endcase
      end
      OPC_LOAD: begin
        ctrl.sel_opr_b = 1'b1;
        ctrl.sel_wb    = WB_MEM;
        ctrl.access    = ACC_LOAD;
      end
      OPC_STORE: begin
        ctrl.sel_opr_b = 1'b1;
        ctrl.imm_type  = IMM_S;
        ctrl.access    = ACC_STORE;
      end
      OPC_OPIMM: begin
        // Only SRAI uses funct7; ADDI never becomes SUB.
        ctrl.sel_opr_b = 1'b1;
        ctrl.aluop     = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_OP: begin
        ctrl.aluop = alu_from_funct3(funct3,
                       funct7[5] && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        illegal    = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// req/ack handshakes with timeout, sticky traps and a retired-instruction count.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                im_ack,
  input  logic                dm_ack,
  output logic                im_req,
  output logic                dm_req,
  output logic                dm_we,
  output logic                ir_en,
  output logic                pc_en,
  output logic                rf_en,
  output logic                sel_opr_a,
  output logic                sel_opr_b,
  output logic [1:0]          sel_wb,
  output logic [2:0]          imm_type,
  output logic [3:0]          aluop,
  output logic [2:0]          brop,
  output logic                illegal,
  output logic                bus_err,
  output logic [RETIRE_W-1:0] retire_cnt
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state, state_nxt;
  ctrl_word_t        dec_ctrl;
  ctrl_word_t        ctrl_p1;
  logic              dec_illegal;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;
  logic              waiting;
  logic              set_illegal;
  logic              set_bus_err;
  logic              cw_active;

  rv32i_decoder u_decoder (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // The current unacked cycle is the TIMEOUT_CYCLES-th one; an ack in that
  // same cycle is checked first and wins.
  assign wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
  assign waiting      = ((state == S_FETCH) && !im_ack) || ((state == S_MEM) && !dm_ack);

  always_comb begin
    state_nxt   = state;
    im_req      = 1'b0;
    dm_req      = 1'b0;
    dm_we       = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    rf_en       = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;

    if (!rst) begin
      case (state)
        S_FETCH: begin
          im_req = 1'b1;
          if (im_ack) begin
            ir_en     = 1'b1;
            state_nxt = S_DECODE;
          end else if (wait_expired) begin
            set_bus_err = 1'b1;
            state_nxt   = S_TRAP;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            set_illegal = 1'b1;
            state_nxt   = S_TRAP;
          end else begin
            state_nxt = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (ctrl_p1.access)
            ACC_BRANCH: begin
              pc_en     = 1'b1;
              state_nxt = S_FETCH;
            end
            ACC_LOAD, ACC_STORE: state_nxt = S_MEM;
            default:             state_nxt = S_WB;
          endcase
        end
        S_MEM: begin
          dm_req = 1'b1;
          dm_we  = (ctrl_p1.access == ACC_STORE);
          if (dm_ack) begin
            if (ctrl_p1.access == ACC_STORE) begin
              pc_en     = 1'b1;
              state_nxt = S_FETCH;
            end else begin
              state_nxt = S_WB;
            end
          end else if (wait_expired) begin
            set_bus_err = 1'b1;
            state_nxt   = S_TRAP;
          end
        end
        S_WB: begin
          rf_en     = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end
        S_TRAP:  state_nxt = S_TRAP;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      if (pc_en) retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end

  // Decode -> execute boundary: control word captured at the end of DECODE.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) ctrl_p1 <= dec_ctrl;
  end

  assign cw_active = !rst && ((state == S_EXECUTE) || (state == S_MEM) || (state == S_WB));

  always_comb begin
    sel_opr_a = 1'b0;
    sel_opr_b = 1'b0;
    sel_wb    = 2'b00;
    imm_type  = 3'b000;
    aluop     = 4'b0000;
    brop      = 3'b000;
    if (cw_active) begin
      sel_opr_a = ctrl_p1.sel_opr_a;
      sel_opr_b = ctrl_p1.sel_opr_b;
      sel_wb    = ctrl_p1.sel_wb;
      imm_type  = ctrl_p1.imm_type;
      aluop     = ctrl_p1.aluop;
      brop      = ctrl_p1.brop;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction table, hand sequences
// for reset/trap/timeout corners, and random instructions against a reference model.
module tb_multicycle_controller;

  localparam int TO = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic          im_ack = 1'b0;
  logic          dm_ack = 1'b0;
  logic          im_req, dm_req, dm_we, ir_en, pc_en, rf_en;
  logic          sel_opr_a, sel_opr_b;
  logic [1:0]    sel_wb;
  logic [2:0]    imm_type;
  logic [3:0]    aluop;
  logic [2:0]    brop;
  logic          illegal, bus_err;
  logic [RW-1:0] retire_cnt;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(TO), .RETIRE_W(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .im_ack     (im_ack),
    .dm_ack     (dm_ack),
    .im_req     (im_req),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .rf_en      (rf_en),
    .sel_opr_a  (sel_opr_a),
    .sel_opr_b  (sel_opr_b),
    .sel_wb     (sel_wb),
    .imm_type   (imm_type),
    .aluop      (aluop),
    .brop       (brop),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .retire_cnt (retire_cnt)
  );

  typedef struct packed {
    logic       sel_a;
    logic       sel_b;
    logic [1:0] sel_wb;
    logic [2:0] imm;
    logic [3:0] aluop;
    logic [2:0] brop;
  } cw_t;

  typedef struct packed {
    logic im_req, dm_req, dm_we, ir_en, pc_en, rf_en;
    cw_t  cw;
    logic illegal, bus_err;
  } obs_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int         im_d;
    int         dm_d;
    cw_t        cw;
    logic       ill;
    string      name;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   retired = 0;
  logic exp_ill = 1'b0;
  logic exp_berr = 1'b0;
  obs_t act;

  assign act = {im_req, dm_req, dm_we, ir_en, pc_en, rf_en, sel_opr_a, sel_opr_b,
                sel_wb, imm_type, aluop, brop, illegal, bus_err};

  // funct3-indexed tables straight from the RV32I encoding
  logic [3:0] alu_tbl [8] = '{4'b0000, 4'b0110, 4'b0011, 4'b0100,
                              4'b0010, 4'b0101, 4'b1001, 4'b1010};
  logic [2:0] br_tbl  [8] = '{3'b001, 3'b010, 3'b000, 3'b000,
                              3'b011, 3'b100, 3'b101, 3'b110};

  function automatic cw_t mk(input logic a, input logic b, input logic [1:0] wb,
                             input logic [2:0] imm, input logic [3:0] alu, input logic [2:0] br);
    cw_t c;
    c.sel_a = a; c.sel_b = b; c.sel_wb = wb; c.imm = imm; c.aluop = alu; c.brop = br;
    return c;
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] v;
    v = alu_tbl[f3];
    if (alt && f3 == 3'd0) v = 4'b0001;
    if (alt && f3 == 3'd5) v = 4'b0111;
    return v;
  endfunction

  function automatic void model(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                output cw_t cw, output logic ill);
    cw  = '0;
    ill = 1'b0;
    case (o)
      7'b0110011: begin
        ill      = !(f7 == 7'h00 || f7 == 7'h20);
        cw.aluop = alu_of(f3, f7[5] && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'b0010011: begin cw.sel_b = 1'b1; cw.aluop = alu_of(f3, f7[5] && f3 == 3'd5); end
      7'b0000011: begin cw.sel_b = 1'b1; cw.sel_wb = 2'b01; end
      7'b0100011: begin cw.sel_b = 1'b1; cw.imm = 3'b010; end
      7'b1100011: begin cw.imm = 3'b001; cw.aluop = 4'b0001; cw.brop = br_tbl[f3]; end
      7'b0110111: begin cw.sel_b = 1'b1; cw.imm = 3'b100; cw.aluop = 4'b1000; end
      7'b0010111: begin cw.sel_a = 1'b1; cw.sel_b = 1'b1; cw.imm = 3'b100; end
      7'b1101111: begin cw.sel_a = 1'b1; cw.sel_b = 1'b1; cw.sel_wb = 2'b10; cw.imm = 3'b011; cw.brop = 3'b111; end
      7'b1100111: begin cw.sel_b = 1'b1; cw.sel_wb = 2'b10; cw.brop = 3'b111; end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic jk();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t idle();
    obs_t o;
    o = '0;
    o.illegal = exp_ill;
    o.bus_err = exp_berr;
    return o;
  endfunction

  // Called just after a rising edge: drive acks, compare at the falling edge.
  task automatic cyc(input logic ima, input logic dma, input obs_t e, input string nm);
    im_ack = ima;
    dm_ack = dma;
    #4;
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: outputs got %h want %h", nm, act, e);
    end
    checks++;
    if (retire_cnt !== RW'(retired)) begin
      failures++;
      $display("FAIL %s/retire: got %0d want %0d", nm, retire_cnt, RW'(retired));
    end
    @(posedge clk);
    #1;
    if (e.pc_en) retired++;
  endtask

  task automatic check_trap(input string nm);
    for (int i = 0; i < 3; i++) cyc(jk(), jk(), idle(), {nm, "/trap"});
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    im_ack = 1'b0;
    dm_ack = 1'b0;
    @(posedge clk);
    #1;
    exp_ill = 1'b0;
    exp_berr = 1'b0;
    retired = 0;
    #4;
    checks++;
    if (act !== obs_t'(0) || retire_cnt !== '0) begin
      failures++;
      $display("FAIL %s/reset: outputs got %h cnt %0d want 0", nm, act, retire_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input int im_d, input int dm_d, input cw_t cw, input logic ill,
                           input string nm);
    obs_t e;
    logic ld, st, br;
    opcode = opc; funct3 = f3; funct7 = f7;
    ld = !ill && opc == 7'b0000011;
    st = !ill && opc == 7'b0100011;
    br = !ill && opc == 7'b1100011;
    for (int i = 0; i <= im_d; i++) begin
      e = idle();
      e.im_req = 1'b1;
      if (i == im_d) begin
        e.ir_en = 1'b1;
        cyc(1'b1, 1'b0, e, {nm, "/fetch_ack"});
      end else begin
        cyc(1'b0, 1'b0, e, {nm, "/fetch_wait"});
        if (i + 1 == TO) begin
          exp_berr = 1'b1;
          check_trap(nm);
          return;
        end
      end
    end
    cyc(jk(), 1'b0, idle(), {nm, "/decode"});
    if (ill) begin
      exp_ill = 1'b1;
      check_trap(nm);
      return;
    end
    e = idle();
    e.cw = cw;
    e.pc_en = br;
    cyc(jk(), 1'b0, e, {nm, "/execute"});
    if (br) return;
    if (ld || st) begin
      for (int i = 0; i <= dm_d; i++) begin
        e = idle();
        e.cw = cw;
        e.dm_req = 1'b1;
        e.dm_we = st;
        if (i == dm_d) begin
          e.pc_en = st;
          cyc(jk(), 1'b1, e, {nm, "/mem_ack"});
        end else begin
          cyc(jk(), 1'b0, e, {nm, "/mem_wait"});
          if (i + 1 == TO) begin
            exp_berr = 1'b1;
            check_trap(nm);
            return;
          end
        end
      end
    end
    if (st) return;
    e = idle();
    e.cw = cw;
    e.rf_en = 1'b1;
    e.pc_en = 1'b1;
    cyc(jk(), 1'b0, e, {nm, "/wb"});
  endtask

  vec_t tbl[$];
  logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

  initial begin
    obs_t e;
    cw_t  cw;
    logic ill;
    logic [6:0] ro, rf7;
    logic [2:0] rf3;
    int   sel;

    tbl.push_back('{7'b0110011, 3'b000, 7'h00, 1, 0, mk(0, 0, 2'b00, 3'b000, 4'b0000, 3'b000), 1'b0, "add"});
    tbl.push_back('{7'b0110011, 3'b000, 7'h20, 0, 0, mk(0, 0, 2'b00, 3'b000, 4'b0001, 3'b000), 1'b0, "sub"});
    tbl.push_back('{7'b0110011, 3'b100, 7'h00, 0, 0, mk(0, 0, 2'b00, 3'b000, 4'b0010, 3'b000), 1'b0, "xor"});
    tbl.push_back('{7'b0110011, 3'b101, 7'h20, 2, 0, mk(0, 0, 2'b00, 3'b000, 4'b0111, 3'b000), 1'b0, "sra"});
    tbl.push_back('{7'b0110011, 3'b101, 7'h00, 0, 0, mk(0, 0, 2'b00, 3'b000, 4'b0101, 3'b000), 1'b0, "srl"});
    tbl.push_back('{7'b0110011, 3'b001, 7'h00, 0, 0, mk(0, 0, 2'b00, 3'b000, 4'b0110, 3'b000), 1'b0, "sll"});
    tbl.push_back('{7'b0110011, 3'b011, 7'h00, 0, 0, mk(0, 0, 2'b00, 3'b000, 4'b0100, 3'b000), 1'b0, "sltu"});
    tbl.push_back('{7'b0110011, 3'b111, 7'h00, 0, 0, mk(0, 0, 2'b00, 3'b000, 4'b1010, 3'b000), 1'b0, "and"});
    tbl.push_back('{7'b0000011, 3'b010, 7'h00, 0, 3, mk(0, 1, 2'b01, 3'b000, 4'b0000, 3'b000), 1'b0, "lw"});
    tbl.push_back('{7'b0100011, 3'b010, 7'h00, 0, 2, mk(0, 1, 2'b00, 3'b010, 4'b0000, 3'b000), 1'b0, "sw"});
    tbl.push_back('{7'b1100011, 3'b001, 7'h00, 0, 0, mk(0, 0, 2'b00, 3'b001, 4'b0001, 3'b010), 1'b0, "bne"});
    tbl.push_back('{7'b1100011, 3'b111, 7'h00, 0, 0, mk(0, 0, 2'b00, 3'b001, 4'b0001, 3'b110), 1'b0, "bgeu"});
    tbl.push_back('{7'b0110111, 3'b000, 7'h00, 0, 0, mk(0, 1, 2'b00, 3'b100, 4'b1000, 3'b000), 1'b0, "lui"});
    tbl.push_back('{7'b0010111, 3'b000, 7'h00, 0, 0, mk(1, 1, 2'b00, 3'b100, 4'b0000, 3'b000), 1'b0, "auipc"});
    tbl.push_back('{7'b1101111, 3'b000, 7'h00, 0, 0, mk(1, 1, 2'b10, 3'b011, 4'b0000, 3'b111), 1'b0, "jal"});
    tbl.push_back('{7'b1100111, 3'b000, 7'h00, 0, 0, mk(0, 1, 2'b10, 3'b000, 4'b0000, 3'b111), 1'b0, "jalr"});
    tbl.push_back('{7'b0010011, 3'b000, 7'h20, 0, 0, mk(0, 1, 2'b00, 3'b000, 4'b0000, 3'b000), 1'b0, "addi"});
    tbl.push_back('{7'b0010011, 3'b101, 7'h20, 0, 0, mk(0, 1, 2'b00, 3'b000, 4'b0111, 3'b000), 1'b0, "srai"});
    tbl.push_back('{7'b0110011, 3'b000, 7'h00, 3, 0, mk(0, 0, 2'b00, 3'b000, 4'b0000, 3'b000), 1'b0, "ack_on_last"});
    tbl.push_back('{7'b0110011, 3'b000, 7'h01, 0, 0, '0, 1'b1, "bad_funct7"});
    tbl.push_back('{7'b1111111, 3'b000, 7'h00, 0, 0, '0, 1'b1, "bad_opcode"});
    tbl.push_back('{7'b0110011, 3'b000, 7'h00, 4, 0, '0, 1'b0, "im_timeout"});
    tbl.push_back('{7'b0000011, 3'b010, 7'h00, 0, 4, mk(0, 1, 2'b01, 3'b000, 4'b0000, 3'b000), 1'b0, "dm_timeout"});

    do_reset("init");

    foreach (tbl[i]) begin
      run_instr(tbl[i].opc, tbl[i].f3, tbl[i].f7, tbl[i].im_d, tbl[i].dm_d,
                tbl[i].cw, tbl[i].ill, tbl[i].name);
      if (exp_ill || exp_berr) do_reset(tbl[i].name);
    end

    // reset while a data request is outstanding
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'h00;
    cw = mk(0, 1, 2'b01, 3'b000, 4'b0000, 3'b000);
    e = idle(); e.im_req = 1'b1; e.ir_en = 1'b1;
    cyc(1'b1, 1'b0, e, "mid/fetch");
    cyc(1'b0, 1'b0, idle(), "mid/decode");
    e = idle(); e.cw = cw;
    cyc(1'b0, 1'b0, e, "mid/execute");
    e.dm_req = 1'b1;
    cyc(1'b0, 1'b0, e, "mid/mem_wait");
    rst = 1'b1;
    #4;
    checks++;
    if (act !== obs_t'(0)) begin
      failures++;
      $display("FAIL mid/req_drop: outputs got %h want 0", act);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    retired = 0;
    run_instr(7'b0110011, 3'b000, 7'h00, 0, 0, mk(0, 0, 2'b00, 3'b000, 4'b0000, 3'b000), 1'b0, "mid/after");

    // random instruction stream; retire count wraps at 2^RW
    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 10));
      ro  = (sel < 9) ? ops[sel] : 7'($urandom);
      rf3 = 3'($urandom);
      rf7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00);
      model(ro, rf3, rf7, cw, ill);
      run_instr(ro, rf3, rf7, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                cw, ill, "rand");
      if (exp_ill || exp_berr) do_reset("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
